// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: parses a counted, XOR-checksummed frame,
// writes little-endian 32-bit words from address 0 and holds the core until verified.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] DEPTH_N = 17'(DEPTH);

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [23:0]         sh_q, sh_d;
  logic [7:0]          xor_q, xor_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                hold_q, hold_d;

  logic        acc;
  logic [15:0] n_full;
  logic        last_word;
  logic        restart;

  assign acc       = in_valid && in_ready;
  assign n_full    = {in_data, cnt_q[7:0]};
  // The word being completed is the final one when words_loaded+1 reaches N
  assign last_word = (17'(words_q) + 17'd1) == {1'b0, cnt_q};
  assign restart   = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      xor_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      words_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      xor_q   <= xor_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      words_q <= words_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_HDR0;
      S_HDR0: if (acc) state_d = S_HDR1;
      S_HDR1: if (acc) begin
        if ({1'b0, n_full} > DEPTH_N) state_d = S_ERR;
        else if (n_full == 16'd0)     state_d = S_CSUM;
        else                          state_d = S_DATA;
      end
      S_DATA: if (acc && bcnt_q == 2'd3 && last_word) state_d = S_CSUM;
      S_CSUM: if (acc) state_d = (in_data == xor_q) ? S_DONE : S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_HDR0) || (state_q == S_HDR1) ||
               (state_q == S_DATA) || (state_q == S_CSUM);
    cnt_d    = cnt_q;
    bcnt_d   = bcnt_q;
    sh_d     = sh_q;
    xor_d    = xor_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    words_d  = words_q;
    done_d   = done_q;
    err_d    = err_q;
    hold_d   = hold_q;
    if (restart) begin
      bcnt_d  = '0;
      xor_d   = '0;
      words_d = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      hold_d  = 1'b1;
    end
    if (acc) begin
      case (state_q)
        S_HDR0: cnt_d[7:0] = in_data;
        S_HDR1: begin
          cnt_d = n_full;
          if ({1'b0, n_full} > DEPTH_N) err_d = 1'b1;
        end
        S_DATA: begin
          xor_d  = xor_q ^ in_data;
          bcnt_d = bcnt_q + 2'd1;
          // Bytes enter at the top so the first byte ends up least significant
          sh_d   = {in_data, sh_q[23:8]};
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = words_q[ADDR_W-1:0];
            wdata_d = {in_data, sh_q};
            words_d = words_q + 1'b1;
          end
        end
        S_CSUM: begin
          if (in_data == xor_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign core_hold    = hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of frames plus a write scoreboard.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_we, core_hold, done, err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] words_loaded;

  imem_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [9:0] a; logic [31:0] d; } wr_t;
  typedef struct {
    logic [15:0] n; int idx; int nw; bit bad; bit gaps;
    bit exp_done; bit exp_err; int exp_words;
  } vec_t;

  wr_t         q[$];
  int          errors = 0;
  int          checks = 0;
  bit          stalled;
  logic [31:0] progw[9];
  vec_t        vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every observed write must match the oldest expected one
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      if (q.size() == 0) begin
        chk("unexpected_write", {22'd0, mem_addr, mem_wdata}, 64'd0);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e.a));
        chk("wr_data", 64'(mem_wdata), 64'(e.d));
        chk("wr_words", 64'(words_loaded), 64'(e.a) + 64'd1);
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic st);
    start = st; in_data = b; in_valid = 1'b1;
    if (!in_ready) stalled = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic send_word(input int k, input logic [31:0] w, input bit gaps,
                           input bit midstart, inout logic [7:0] x);
    logic [7:0] bt;
    for (int b = 0; b < 4; b++) begin
      bt = w[8*b +: 8];
      x  = x ^ bt;
      if (b == 3) q.push_back({10'(k), w});
      if (gaps && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      send(bt, midstart && b == 2);
    end
  endtask

  task automatic run_frame(input vec_t v, input bit do_start, input string tag);
    logic [7:0] x;
    if (do_start) begin
      start = 1'b1; @(negedge clk); start = 1'b0;
    end
    chk({tag, "_rdy_hdr0"}, 64'(in_ready), 64'd1);
    stalled = 1'b0;
    x = 8'h00;
    send(v.n[7:0], 1'b0);
    send(v.n[15:8], 1'b0);
    if (v.n <= 16'd1024) begin
      for (int w = 0; w < v.nw; w++) begin
        if (v.gaps && w == 2) begin
          start = 1'b1; @(negedge clk); start = 1'b0;
        end
        send_word(w, progw[v.idx + w], v.gaps, v.gaps && w == 1, x);
      end
      send(v.bad ? (x ^ 8'h01) : x, 1'b0);
    end
    chk({tag, "_done"}, 64'(done), 64'(v.exp_done));
    chk({tag, "_err"}, 64'(err), 64'(v.exp_err));
    chk({tag, "_hold"}, 64'(core_hold), 64'(!v.exp_done));
    chk({tag, "_words"}, 64'(words_loaded), 64'(v.exp_words));
    chk({tag, "_rdy_end"}, 64'(in_ready), 64'd0);
    chk({tag, "_stall"}, 64'(stalled), 64'd0);
    @(negedge clk);
    chk({tag, "_sb_empty"}, 64'(q.size()), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, 64'(in_ready), 64'd0);
    chk({tag, "_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_hold"}, 64'(core_hold), 64'd1);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] x;
    vec_t v;
    progw = '{32'h00a00093, 32'h01400113, 32'h01900193, 32'h0073e3b3, 32'h0073e3b3,
              32'h00208233, 32'h0073e3b3, 32'h003202b3, 32'h0000707f};
    //        n        idx nw bad gaps done err words
    vecs[0] = '{16'd9,    0, 9, 1'b0, 1'b0, 1'b1, 1'b0, 9};
    vecs[1] = '{16'd1,    0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[2] = '{16'd1,    0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    vecs[3] = '{16'd1025, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[4] = '{16'd0,    0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[5] = '{16'd9,    0, 9, 1'b0, 1'b1, 1'b1, 1'b0, 9};

    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rdy", 64'(in_ready), 64'd0);

    for (int i = 0; i < 6; i++) run_frame(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Reset after two of three words: everything returns to reset values at once
    start = 1'b1; @(negedge clk); start = 1'b0;
    x = 8'h00;
    send(8'h03, 1'b0);
    send(8'h00, 1'b0);
    send_word(0, progw[0], 1'b0, 1'b0, x);
    send_word(1, progw[1], 1'b0, 1'b0, x);
    #2 rst = 1'b1;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    v = '{16'd3, 0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    run_frame(v, 1'b1, "after_rst");

    // Start in DONE re-holds the core next cycle; second image overwrites from 0
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("redo_hold", 64'(core_hold), 64'd1);
    chk("redo_done", 64'(done), 64'd0);
    chk("redo_words", 64'(words_loaded), 64'd0);
    v = '{16'd4, 5, 4, 1'b0, 1'b0, 1'b1, 1'b0, 4};
    run_frame(v, 1'b0, "second_img");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
